sqrt_arbiter: RTL

Shares one `sqrt_calculator` core among up to `N_REQ` requesters (e.g. several memory-mapped peripherals or a CPU port plus a DMA-style sequencer). Grants the core round-robin, launches one operation per grant, waits for the core's `done` under a watchdog, and returns the 8-bit root to the winning requester with a one-cycle response pulse. Sits between the requester-side peripheral wrappers and a single `sqrt_calculator` instance.

---
 rtl/sqrt_arbiter_if.sv | 30 +++
 rtl/sqrt_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter_if.sv
// Requester-side and core-side signals of the shared sqrt arbiter.
// Handshake: a requester holds req and its req_a slice stable until its resp_valid bit
// pulses for one cycle; core_start is a one-cycle launch, and core_x/core_valid are sampled only with core_done.
interface sqrt_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_a;
  logic [N_REQ-1:0]   resp_valid;
  logic [7:0]         resp_x;
  logic               resp_ok;
  logic               busy;
  logic               core_start;
  logic [7:0]         core_a;
  logic [7:0]         core_x;
  logic               core_done;
  logic               core_valid;

  // Environment side: requesters plus the sqrt core.
  modport master (
    output req, req_a, core_x, core_done, core_valid,
    input  resp_valid, resp_x, resp_ok, busy, core_start, core_a
  );

  // Arbiter side.
  modport slave (
    input  req, req_a, core_x, core_done, core_valid,
    output resp_valid, resp_x, resp_ok, busy, core_start, core_a
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt core among N_REQ requesters, with a
// watchdog on the core's done and a one-cycle one-hot response pulse.
module sqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  sqrt_arbiter_if.slave bus,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] winner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] resp_valid_q;
  logic [7:0]       resp_x_q;
  logic             resp_ok_q;
  logic             busy_q;
  logic             core_start_q;
  logic [7:0]       core_a_q;

  logic [IDX_W-1:0] win_d;
  logic [7:0]       win_a_d;

  // First set request at or above ptr, wrapping; the downward scan lets the
  // closest candidate to ptr overwrite any farther one.
  function automatic logic [IDX_W-1:0] pick_winner(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] w;
    int j;
    w = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (r[j]) w = IDX_W'(j);
    end
    return w;
  endfunction

  always_comb begin
    win_d   = pick_winner(bus.req, rr_ptr_q);
    win_a_d = bus.req_a[{win_d, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_x_q     <= '0;
      resp_ok_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            winner_q     <= win_d;
            core_a_q     <= win_a_d;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          core_start_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A done landing on the watchdog limit still returns the core result.
          if (bus.core_done) begin
            resp_x_q     <= bus.core_x;
            resp_ok_q    <= bus.core_valid;
            resp_valid_q <= N_REQ'(1) << winner_q;
            state_q      <= S_RESP;
          end else if (cnt_q == CNT_LIMIT) begin
            resp_x_q     <= '0;
            resp_ok_q    <= 1'b0;
            resp_valid_q <= N_REQ'(1) << winner_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid_q <= '0;
          busy_q       <= 1'b0;
          rr_ptr_q     <= (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_x     = resp_x_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.busy       = busy_q;
  assign bus.core_start = core_start_q;
  assign bus.core_a     = core_a_q;
  assign dbg_state_o    = state_q;

endmodule
